// File: rtl/kitchen_pkg.sv
// Shared kitchen definitions: ingredient state bits, dispatcher states and the dish menu.
// Dishes are {chicken, tomato, rice, onion}, three state bits per ingredient.
package kitchen_pkg;

   localparam logic [2:0] ST_NONE    = 3'b000;
   localparam logic [2:0] ST_RAW     = 3'b001;
   localparam logic [2:0] ST_CHOPPED = 3'b010;
   localparam logic [2:0] ST_BOILED  = 3'b100;

   typedef logic [11:0] dish_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_PLAY,
      S_DONE,
      S_OVER
   } state_t;

   // Element [0] is the rightmost entry.
   localparam logic [7:0][11:0] MENU = {
      12'b010_000_000_001,
      12'b000_000_001_000,
      12'b000_010_000_000,
      12'b001_000_000_000,
      12'b000_001_000_010,
      12'b010_000_001_000,
      12'b000_000_001_010,
      12'b001_010_000_000
   };

endpackage

// File: rtl/order_dispatcher_if.sv
// Dispatcher <-> ingredient_management link: three orders out, sticky done flags back.
interface order_dispatcher_if;
   import kitchen_pkg::*;

   dish_t      order_1;
   dish_t      order_2;
   dish_t      order_3;
   logic       server_reset;
   logic [2:0] orders_done;

   modport master (output order_1, order_2, order_3, server_reset, input orders_done);
   modport slave  (input order_1, order_2, order_3, server_reset, output orders_done);
endinterface

// File: rtl/order_dispatcher_lfsr16.sv
// 16-bit Galois LFSR with loadable seed; exposes only the low OUT_W bits.
module lfsr16 #(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter logic [15:0] TAPS  = 16'hB400,
   parameter int          OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [OUT_W-1:0] q
);
   logic [15:0] state;

   always_ff @(posedge clk) begin
      if (rst)     state <= SEED;
      else if (en) state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
   end

   assign q = state[OUT_W-1:0];
endmodule

// File: rtl/order_dispatcher.sv
// Round loop for the kitchen game: draws three distinct dishes, times the round,
// scores completed orders and tracks won/failed rounds.
module order_dispatcher
   import kitchen_pkg::*;
#(
   parameter int          TICKS_PER_SEC = 100_000_000,
   parameter int          ROUND_SECONDS = 60,
   parameter int          MAX_FAILS     = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic               basys_clk,
   input  logic               reset,
   input  logic               start,
   order_dispatcher_if.master srv,
   output logic               playing,
   output logic [6:0]         time_left,
   output logic [7:0]         score,
   output logic [3:0]         rounds_won,
   output logic [1:0]         fails,
   output logic               game_over,
   output logic               round_won,
   output logic               round_lost
);
   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   state_t        state, state_nx;
   dish_t         slot_1, slot_2, slot_3, cand;
   logic [2:0]    pick, prev_done, rise, fails_inc;
   logic [1:0]    fill_idx;
   logic [TW-1:0] tick;
   logic [8:0]    score_sum;
   logic          won_q, cand_ok, all_done, tick_wrap, timeout, enter_gen, start_game;

   lfsr16 #(.SEED(LFSR_SEED), .OUT_W(3)) u_lfsr (
      .clk (basys_clk),
      .rst (reset),
      .en  (1'b1),
      .q   (pick)
   );

   // Unfilled slots hold zero and no menu dish is zero, so all three compares are safe.
   always_comb begin
      cand      = MENU[pick];
      cand_ok   = (cand != slot_1) && (cand != slot_2) && (cand != slot_3);
      rise      = srv.orders_done & ~prev_done;
      all_done  = (srv.orders_done == 3'b111);
      tick_wrap = (tick == TW'(TICKS_PER_SEC - 1));
      timeout   = tick_wrap && (time_left == 7'd1);
      fails_inc = {1'b0, fails} + 3'd1;
      score_sum = {1'b0, score} + 9'(rise[0]) + 9'(rise[1]) + 9'(rise[2]);
   end

   always_ff @(posedge basys_clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx         = state;
      enter_gen        = 1'b0;
      start_game       = 1'b0;
      playing          = 1'b0;
      game_over        = 1'b0;
      round_won        = 1'b0;
      round_lost       = 1'b0;
      srv.server_reset = 1'b1;
      srv.order_1      = '0;
      srv.order_2      = '0;
      srv.order_3      = '0;
      case (state)
         S_IDLE, S_OVER: begin
            game_over = (state == S_OVER);
            if (start) begin
               state_nx   = S_GEN;
               enter_gen  = 1'b1;
               start_game = 1'b1;
            end
         end
         S_GEN: if (cand_ok && fill_idx == 2'd2) state_nx = S_PLAY;
         S_PLAY: begin
            playing          = 1'b1;
            srv.server_reset = 1'b0;
            srv.order_1      = slot_1;
            srv.order_2      = slot_2;
            srv.order_3      = slot_3;
            if (all_done || timeout) state_nx = S_DONE;
         end
         S_DONE: begin
            round_won  = won_q;
            round_lost = !won_q;
            if (!won_q && fails_inc == 3'(MAX_FAILS)) begin
               state_nx = S_OVER;
            end else begin
               state_nx  = S_GEN;
               enter_gen = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge basys_clk) begin
      if (reset) begin
         slot_1     <= '0;
         slot_2     <= '0;
         slot_3     <= '0;
         fill_idx   <= '0;
         prev_done  <= '0;
         tick       <= '0;
         time_left  <= '0;
         score      <= '0;
         rounds_won <= '0;
         fails      <= '0;
         won_q      <= 1'b0;
      end else begin
         // Edge register tracks the flags in every state, cleared on each new round.
         prev_done <= enter_gen ? 3'b000 : srv.orders_done;
         if (start_game) begin
            score      <= '0;
            rounds_won <= '0;
            fails      <= '0;
         end
         if (enter_gen) begin
            slot_1   <= '0;
            slot_2   <= '0;
            slot_3   <= '0;
            fill_idx <= '0;
         end
         case (state)
            S_GEN: if (cand_ok) begin
               case (fill_idx)
                  2'd0:    slot_1 <= cand;
                  2'd1:    slot_2 <= cand;
                  default: slot_3 <= cand;
               endcase
               fill_idx <= fill_idx + 2'd1;
               if (fill_idx == 2'd2) begin
                  time_left <= 7'(ROUND_SECONDS);
                  tick      <= '0;
               end
            end
            S_PLAY: begin
               score <= score_sum[8] ? 8'hFF : score_sum[7:0];
               won_q <= all_done;
               tick  <= tick_wrap ? '0 : tick + 1'b1;
               if (tick_wrap) time_left <= time_left - 7'd1;
            end
            S_DONE: begin
               if (won_q) rounds_won <= rounds_won + 4'd1;
               else       fails      <= fails_inc[1:0];
            end
            default: ;
         endcase
      end
   end
endmodule
